// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of a single-ported, synchronous-read data memory.
// Default build: core priority with a debug starvation guard; define DMEM_ARB_RR_EN for round-robin on contested cycles.
module dmem_arbiter #(
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 32,
  parameter int WAIT_MAX = 4
) (
  input  logic              clk,
  input  logic              RN,
  input  logic              c_req,
  input  logic              c_we,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic [DATA_W-1:0] c_wdata,
  output logic              c_gnt,
  output logic              c_rvalid,
  output logic [DATA_W-1:0] c_rdata,
  output logic              c_stall,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              m_en,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata
);

  logic [3:0] r_wait_cnt;
  logic       r_last_d;
  logic       r_c_rvalid;
  logic       r_d_rvalid;

  logic       w_d_pick;
  logic       w_c_gnt;
  logic       w_d_gnt;

  // w_d_pick decides only contested cycles; uncontested requests always win.
  always_comb begin
    w_d_pick = 1'b0;
`ifdef DMEM_ARB_RR_EN
    w_d_pick = ~r_last_d;
`else
    w_d_pick = (int'(r_wait_cnt) >= WAIT_MAX);
`endif
  end

  assign w_c_gnt = ~RN & c_req & (~d_req | ~w_d_pick);
  assign w_d_gnt = ~RN & d_req & (~c_req | w_d_pick);

  always_comb begin
    m_en    = w_c_gnt | w_d_gnt;
    m_we    = 1'b0;
    m_addr  = '0;
    m_wdata = '0;
    if (w_c_gnt) begin
      m_we    = c_we;
      m_addr  = c_addr;
      m_wdata = c_wdata;
    end else if (w_d_gnt) begin
      m_we    = d_we;
      m_addr  = d_addr;
      m_wdata = d_wdata;
    end
  end

  always_ff @(posedge clk or posedge RN) begin
    if (RN) begin
      r_wait_cnt <= 4'd0;
      r_last_d   <= 1'b0;
      r_c_rvalid <= 1'b0;
      r_d_rvalid <= 1'b0;
    end else begin
      r_c_rvalid <= w_c_gnt & ~c_we;
      r_d_rvalid <= w_d_gnt & ~d_we;
      if (d_req & ~w_d_gnt) begin
        if (r_wait_cnt != 4'hF) r_wait_cnt <= r_wait_cnt + 4'd1;
      end else begin
        r_wait_cnt <= 4'd0;
      end
      if (w_c_gnt)      r_last_d <= 1'b0;
      else if (w_d_gnt) r_last_d <= 1'b1;
    end
  end

  // Read data is forced to zero outside its one-cycle valid pulse.
  assign c_gnt    = w_c_gnt;
  assign d_gnt    = w_d_gnt;
  assign c_stall  = c_req & ~w_c_gnt;
  assign c_rvalid = r_c_rvalid;
  assign d_rvalid = r_d_rvalid;
  assign c_rdata  = r_c_rvalid ? m_rdata : '0;
  assign d_rdata  = r_d_rvalid ? m_rdata : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios then random traffic, checked by a
// per-cycle expected-response queue against a behavioural memory/arbitration model.
module tb_dmem_arbiter;

  localparam int WAIT_MAX = 4;

  logic        clk = 1'b0;
  logic        RN;
  logic        c_req, c_we, d_req, d_we;
  logic [4:0]  c_addr, d_addr;
  logic [31:0] c_wdata, d_wdata;
  logic        c_gnt, c_rvalid, c_stall, d_gnt, d_rvalid;
  logic [31:0] c_rdata, d_rdata;
  logic        m_en, m_we;
  logic [4:0]  m_addr;
  logic [31:0] m_wdata, m_rdata;

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_W(5), .DATA_W(32), .WAIT_MAX(WAIT_MAX)) dut (
    .clk(clk), .RN(RN),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata), .c_stall(c_stall),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata)
  );

  // Synchronous-read memory the arbiter sits in front of
  logic [31:0] mem [32];
  logic [31:0] mem_rd = 32'd0;
  always @(posedge clk) begin
    if (m_en) begin
      if (m_we) mem[m_addr] = m_wdata;
      else      mem_rd <= mem[m_addr];
    end
  end
  assign m_rdata = mem_rd;

  typedef struct packed {
    logic        c_gnt;
    logic        d_gnt;
    logic        c_stall;
    logic        m_en;
    logic        m_we;
    logic [4:0]  m_addr;
    logic [31:0] m_wdata;
    logic        c_rv;
    logic [31:0] c_rdata;
    logic        d_rv;
    logic [31:0] d_rdata;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int failures = 0;

  // Reference model state: memory contents, consecutive debug denials, last winner, reads in flight
  logic [31:0] mdl_mem [32];
  int          mdl_denied = 0;
  bit          mdl_last_d = 1'b0;
  bit          pc_rd = 1'b0, pd_rd = 1'b0;
  logic [31:0] pc_data = 32'd0, pd_data = 32'd0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  exp_t mon_e;
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      mon_e = exp_q.pop_front();
      chk("c_gnt",    32'(c_gnt),    32'(mon_e.c_gnt));
      chk("d_gnt",    32'(d_gnt),    32'(mon_e.d_gnt));
      chk("c_stall",  32'(c_stall),  32'(mon_e.c_stall));
      chk("m_en",     32'(m_en),     32'(mon_e.m_en));
      if (mon_e.m_en) begin
        chk("m_we",    32'(m_we),    32'(mon_e.m_we));
        chk("m_addr",  32'(m_addr),  32'(mon_e.m_addr));
        chk("m_wdata", m_wdata,      mon_e.m_wdata);
      end
      chk("c_rvalid", 32'(c_rvalid), 32'(mon_e.c_rv));
      chk("c_rdata",  c_rdata,       mon_e.c_rdata);
      chk("d_rvalid", 32'(d_rvalid), 32'(mon_e.d_rv));
      chk("d_rdata",  d_rdata,       mon_e.d_rdata);
    end
  end

  // One clock of stimulus: apply inputs after the edge, predict the cycle's response, queue it.
  task automatic step(input bit rst,
                      input bit cr, input bit cw, input logic [4:0] ca, input logic [31:0] cd,
                      input bit dr, input bit dw, input logic [4:0] da, input logic [31:0] dd,
                      output bit cg, output bit dg);
    exp_t e;
    bit   d_first;
    @(posedge clk);
    #1;
    RN = rst;
    c_req = cr; c_we = cw; c_addr = ca; c_wdata = cd;
    d_req = dr; d_we = dw; d_addr = da; d_wdata = dd;
    e = '0;
    cg = 1'b0;
    dg = 1'b0;
`ifdef DMEM_ARB_RR_EN
    d_first = !mdl_last_d;
`else
    d_first = (mdl_denied >= WAIT_MAX);
`endif
    if (!rst) begin
      if (cr && dr) begin
        dg = d_first;
        cg = !d_first;
      end else begin
        cg = cr;
        dg = dr;
      end
      e.c_rv    = pc_rd;
      e.c_rdata = pc_rd ? pc_data : 32'd0;
      e.d_rv    = pd_rd;
      e.d_rdata = pd_rd ? pd_data : 32'd0;
    end
    e.c_gnt   = cg;
    e.d_gnt   = dg;
    e.c_stall = cr && !cg;
    e.m_en    = cg || dg;
    if (cg) begin
      e.m_we = cw; e.m_addr = ca; e.m_wdata = cd;
    end else if (dg) begin
      e.m_we = dw; e.m_addr = da; e.m_wdata = dd;
    end
    pc_rd   = cg && !cw;
    pc_data = mdl_mem[ca];
    pd_rd   = dg && !dw;
    pd_data = mdl_mem[da];
    if (cg && cw) mdl_mem[ca] = cd;
    if (dg && dw) mdl_mem[da] = dd;
    if (rst || !dr || dg) mdl_denied = 0;
    else if (mdl_denied < 15) mdl_denied++;
    if (rst)     mdl_last_d = 1'b0;
    else if (cg) mdl_last_d = 1'b0;
    else if (dg) mdl_last_d = 1'b1;
    exp_q.push_back(e);
  endtask

  task automatic idle(input bit rst);
    bit cg, dg;
    step(rst, 0, 0, 5'd0, 32'd0, 0, 0, 5'd0, 32'd0, cg, dg);
  endtask

  bit          cg, dg;
  bit          cp, cwp, dp, dwp;
  logic [4:0]  cap, dap;
  logic [31:0] cdp, ddp;

  initial begin
    RN = 1'b1;
    c_req = 0; c_we = 0; c_addr = '0; c_wdata = '0;
    d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0;
    for (int i = 0; i < 32; i++) begin
      mem[i] = $urandom;
      mdl_mem[i] = mem[i];
    end
    mem[3] = 32'hDEADBEEF;
    mdl_mem[3] = 32'hDEADBEEF;

    // Reset held: no grants even with both requesting
    idle(1);
    step(1, 1, 0, 5'd1, 32'd0, 1, 0, 5'd2, 32'd0, cg, dg);
    idle(0);

    // Core read of 3, then debug write 7 followed by core read of 7
    step(0, 1, 0, 5'd3, 32'd0, 0, 0, 5'd0, 32'd0, cg, dg);
    step(0, 0, 0, 5'd0, 32'd0, 1, 1, 5'd7, 32'h12345678, cg, dg);
    step(0, 1, 0, 5'd7, 32'd0, 0, 0, 5'd0, 32'd0, cg, dg);
    idle(0);

    // Contention: both hold reads for six cycles
    for (int i = 0; i < 6; i++)
      step(0, 1, 0, 5'd3, 32'd0, 1, 0, 5'd7, 32'd0, cg, dg);
    idle(0);

    // Reset pulsed the cycle after a core read grant
    step(0, 1, 0, 5'd3, 32'd0, 0, 0, 5'd0, 32'd0, cg, dg);
    idle(1);
    step(0, 1, 0, 5'd4, 32'd0, 1, 0, 5'd5, 32'd0, cg, dg);
    idle(0);

    // Idle, then a core write: no read return follows it
    idle(0);
    step(0, 1, 1, 5'd9, 32'hCAFEF00D, 0, 0, 5'd0, 32'd0, cg, dg);
    idle(0);
    step(0, 0, 0, 5'd0, 32'd0, 1, 0, 5'd9, 32'd0, cg, dg);
    idle(0);

    // Random traffic: requesters hold until granted, occasionally withdraw
    cp = 0; dp = 0;
    for (int i = 0; i < 1500; i++) begin
      if (!cp && $urandom_range(0, 99) < 60) begin
        cp = 1; cwp = ($urandom_range(0, 2) == 0);
        cap = 5'($urandom_range(0, 31)); cdp = $urandom;
      end else if (cp && $urandom_range(0, 99) < 3) cp = 0;
      if (!dp && $urandom_range(0, 99) < 45) begin
        dp = 1; dwp = ($urandom_range(0, 1) == 0);
        dap = 5'($urandom_range(0, 31)); ddp = $urandom;
      end else if (dp && $urandom_range(0, 99) < 3) dp = 0;
      step(0, cp, cwp, cap, cdp, dp, dwp, dap, ddp, cg, dg);
      if (cg) cp = 0;
      if (dg) dp = 0;
    end
    idle(0);
    idle(0);

    for (int k = 0; k < 20 && exp_q.size() != 0; k++) @(negedge clk);
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d pending expectations expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
